count_seq_checker: RTL and testbench
====================================

# count_seq_checker

Receive-side checker for free-running binary counter streams. Samples a counter value presented with a valid strobe and verifies each sample equals the previous sample plus one, modulo 2^WIDTH. It acquires lock after a run of consecutive good samples and flags sequence errors while locked. It drops lock after repeated errors. It sits downstream of any free-running counter and is used in-system as a liveness/integrity monitor on counter-derived timebases.

## Interface
- WIDTH, 8: width of the observed count.
- LOCK_CNT, 4: consecutive matching samples required to enter LOCK (≥1).
- UNLOCK_ERRS, 2: consecutive mismatches in LOCK that force return to ACQ (≥1).
- ERR_W, 16: width of the error counter.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample strobe; in_count is examined only when high.
- in_count  in  WIDTH  observed counter value.
- clear  in  1  synchronous clear of err_count only.
- locked  out  1  high while in LOCK.
- err_pulse  out  1  one-cycle pulse per mismatch accepted in LOCK.
- wrap_pulse  out  1  one-cycle pulse when a matching sample in LOCK equals 0.
- err_count  out  ERR_W  saturating count of mismatches accepted in LOCK.
- expected  out  WIDTH  value the next sample must carry.

## Operation
- Match: in_valid && in_count == expected. Comparison is WIDTH bits. expected is always updated as (in_count + 1) mod 2^WIDTH on every accepted sample, match or not. This resyncs to the received value.
- States:
  - IDLE: no reference. First in_valid: load expected, good_run=0, go ACQ.
  - ACQ: match → good_run+1. When good_run+1 == LOCK_CNT → LOCK, bad_run=0. Mismatch → good_run=0, stay ACQ, no err_pulse, err_count unchanged.
  - LOCK: match → bad_run=0. If in_count == 0, assert wrap_pulse. Mismatch → assert err_pulse, err_count+1 (saturating at all-ones), bad_run+1. When bad_run+1 == UNLOCK_ERRS → ACQ, good_run=0.
- in_valid low: no state, counter or expected change. Pulses low.
- clear: sets err_count=0 that cycle. If a counted mismatch occurs in the same cycle, clear wins: err_count=0, err_pulse still asserts. clear does not affect state, locked or expected.
- Saturation: err_count holds at 2^ERR_W−1. err_pulse continues to pulse.
- Internal run counters are sized to hold LOCK_CNT / UNLOCK_ERRS. No wrap.

## Timing
- All outputs are registered. The effect of a sample accepted at edge N is visible on outputs right after edge N, with no additional latency.
- Reset values: locked=0, err_pulse=0, wrap_pulse=0, err_count=0, expected=0, state=IDLE, run counters=0.
- Reset mid-operation: asynchronous return to reset values. The first sample after release is treated as an IDLE capture.
- err_pulse and wrap_pulse are high for exactly one cycle per qualifying sample. Back-to-back qualifying samples give back-to-back pulses.
- locked rises at the edge accepting the LOCK_CNT-th match after capture. It falls at the edge accepting the UNLOCK_ERRS-th consecutive mismatch.
- Samples need not be contiguous in time. Gaps with in_valid low are transparent.

## Test plan
Parameters WIDTH=8, LOCK_CNT=4, UNLOCK_ERRS=2, ERR_W=16 unless stated.
- Acquire: reset, then samples 0x10,0x11,0x12,0x13,0x14 on consecutive cycles → locked=1 after the 0x14 edge; expected=0x15; err_count=0; no pulses.
- Wrap: locked, feed 0xFE,0xFF,0x00,0x01 → wrap_pulse exactly once, on the 0x00 edge; locked stays 1; err_count=0.
- Single error: locked with expected=0x20, feed 0x25 then 0x26 → err_pulse once, err_count=1, expected=0x27, locked stays 1.
- Unlock and reacquire: locked with expected=0x30, feed 0x40,0x50 → err_count=2, locked=0 after 0x50. Then feed 0x51..0x54 → locked=1 again after 0x54; no err_pulse during ACQ.
- Gaps and clear: locked, feed 0x60, idle 5 cycles, 0x61 → no error. Then assert clear in the same cycle as mismatch 0x99 → err_pulse=1, err_count=0.
- Saturation and reset: ERR_W=2, locked, UNLOCK_ERRS=8, 5 mismatches → err_count sticks at 3 and err_pulse fires 5 times. Assert rst_n low mid-stream → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/count_seq_checker.sv
// count_seq_checker
//
// Receive-side integrity monitor for a free-running binary counter stream.
// Every accepted sample (in_valid high) is compared against the value the
// checker expects next; the expectation is then resynchronised to the
// received value plus one, whether or not the sample matched. A run of
// LOCK_CNT consecutive matches after the first capture acquires lock.
// While locked, mismatches are reported and counted. UNLOCK_ERRS
// consecutive mismatches drop lock back to acquisition.
//
// States:
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | no reference yet; next accepted sample is captured
//   S_ACQ  | reference held, counting consecutive matches toward lock
//   S_LOCK | locked; mismatches pulse err_pulse and bump err_count
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   sample strobe; in_count is examined only when high
//   in_count    in   observed counter value (WIDTH)
//   clear       in   synchronous clear of err_count only
//   locked      out  high while in S_LOCK
//   err_pulse   out  one-cycle pulse per mismatch accepted while locked
//   wrap_pulse  out  one-cycle pulse when a matching locked sample is zero
//   err_count   out  saturating count of locked mismatches (ERR_W)
//   expected    out  value the next sample must carry (WIDTH)

module count_seq_checker #(
  parameter int WIDTH       = 8,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_count,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  // Run counters only ever need to reach their thresholds, never wrap.
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);

  localparam logic [GW-1:0] LOCK_TGT   = GW'(LOCK_CNT);
  localparam logic [BW-1:0] UNLOCK_TGT = BW'(UNLOCK_ERRS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t            state;
  logic [GW-1:0]     good_run;
  logic [BW-1:0]     bad_run;

  logic              match;
  logic [GW-1:0]     good_next;
  logic [BW-1:0]     bad_next;
  logic              err_sat;
  logic [ERR_W-1:0]  err_inc;
  logic [WIDTH-1:0]  count_next;

  assign match      = (in_count == expected);
  assign good_next  = good_run + GW'(1);
  assign bad_next   = bad_run + BW'(1);
  assign err_sat    = &err_count;
  assign err_inc    = err_count + ERR_W'(1);
  assign count_next = in_count + WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      good_run   <= '0;
      bad_run    <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
      expected   <= '0;
    end else begin
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;

      if (in_valid) begin
        // Always resync to what was actually received.
        expected <= count_next;

        case (state)
          S_IDLE: begin
            good_run <= '0;
            bad_run  <= '0;
            state    <= S_ACQ;
          end

          S_ACQ: begin
            if (match) begin
              if (good_next == LOCK_TGT) begin
                state    <= S_LOCK;
                locked   <= 1'b1;
                good_run <= '0;
                bad_run  <= '0;
              end else begin
                good_run <= good_next;
              end
            end else begin
              good_run <= '0;
            end
          end

          S_LOCK: begin
            if (match) begin
              bad_run    <= '0;
              wrap_pulse <= (in_count == '0);
            end else begin
              err_pulse <= 1'b1;
              if (!err_sat) begin
                err_count <= err_inc;
              end
              if (bad_next == UNLOCK_TGT) begin
                state    <= S_ACQ;
                locked   <= 1'b0;
                good_run <= '0;
                bad_run  <= '0;
              end else begin
                bad_run <= bad_next;
              end
            end
          end

          default: begin
            state    <= S_IDLE;
            locked   <= 1'b0;
            good_run <= '0;
            bad_run  <= '0;
          end
        endcase
      end

      // Placed last so a same-cycle clear overrides a counted mismatch.
      if (clear) begin
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Testbench for count_seq_checker: two instances (default parameters and
// ERR_W=2 / UNLOCK_ERRS=8) share one stimulus stream; every cycle both are
// compared with a behavioural model, plus directed scenario checks.

module tb_count_seq_checker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_count;
  logic       clear;

  logic        locked_a, err_pulse_a, wrap_pulse_a;
  logic [15:0] err_count_a;
  logic [7:0]  expected_a;

  logic        locked_b, err_pulse_b, wrap_pulse_b;
  logic [1:0]  err_count_b;
  logic [7:0]  expected_b;

  int n_checks = 0;
  int n_fail   = 0;
  int wraps_a  = 0;
  int errs_a   = 0;
  int errs_b   = 0;

  // model state per instance: 0 = no reference, 1 = acquiring, 2 = locked
  int m_st[2], m_good[2], m_bad[2], m_errc[2], m_exp[2];
  int m_err[2], m_wrap[2];
  int m_lock_cnt[2]  = '{4, 4};
  int m_unlock[2]    = '{2, 8};
  int m_errmax[2]    = '{65535, 3};

  count_seq_checker u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count),
    .clear(clear), .locked(locked_a), .err_pulse(err_pulse_a),
    .wrap_pulse(wrap_pulse_a), .err_count(err_count_a), .expected(expected_a)
  );

  count_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .UNLOCK_ERRS(8), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count),
    .clear(clear), .locked(locked_b), .err_pulse(err_pulse_b),
    .wrap_pulse(wrap_pulse_b), .err_count(err_count_b), .expected(expected_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200us");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_good[i] = 0; m_bad[i] = 0; m_errc[i] = 0;
      m_exp[i] = 0; m_err[i] = 0; m_wrap[i] = 0;
    end
  endtask

  task automatic model_step(input bit v, input int c, input bit clr);
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0;
      m_wrap[i] = 0;
      if (v) begin
        if (m_st[i] == 0) begin
          m_st[i] = 1;
          m_good[i] = 0;
        end else if (m_st[i] == 1) begin
          if (c == m_exp[i]) begin
            m_good[i]++;
            if (m_good[i] == m_lock_cnt[i]) begin
              m_st[i] = 2;
              m_bad[i] = 0;
            end
          end else begin
            m_good[i] = 0;
          end
        end else begin
          if (c == m_exp[i]) begin
            m_bad[i] = 0;
            m_wrap[i] = (c == 0) ? 1 : 0;
          end else begin
            m_err[i] = 1;
            if (m_errc[i] < m_errmax[i]) m_errc[i]++;
            m_bad[i]++;
            if (m_bad[i] == m_unlock[i]) begin
              m_st[i] = 1;
              m_good[i] = 0;
            end
          end
        end
        m_exp[i] = (c + 1) % 256;
      end
      if (clr) m_errc[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " locked_a"},     {31'd0, locked_a},     (m_st[0] == 2) ? 1 : 0);
    chk({tag, " err_pulse_a"},  {31'd0, err_pulse_a},  m_err[0]);
    chk({tag, " wrap_pulse_a"}, {31'd0, wrap_pulse_a}, m_wrap[0]);
    chk({tag, " err_count_a"},  {16'd0, err_count_a},  m_errc[0]);
    chk({tag, " expected_a"},   {24'd0, expected_a},   m_exp[0]);
    chk({tag, " locked_b"},     {31'd0, locked_b},     (m_st[1] == 2) ? 1 : 0);
    chk({tag, " err_pulse_b"},  {31'd0, err_pulse_b},  m_err[1]);
    chk({tag, " wrap_pulse_b"}, {31'd0, wrap_pulse_b}, m_wrap[1]);
    chk({tag, " err_count_b"},  {30'd0, err_count_b},  m_errc[1]);
    chk({tag, " expected_b"},   {24'd0, expected_b},   m_exp[1]);
  endtask

  task automatic step(input string tag, input bit v, input int c, input bit clr);
    @(negedge clk);
    in_valid = v;
    in_count = c[7:0];
    clear    = clr;
    @(posedge clk);
    model_step(v, c, clr);
    #1;
    check_all(tag);
    if (wrap_pulse_a) wraps_a++;
    if (err_pulse_a)  errs_a++;
    if (err_pulse_b)  errs_b++;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic acquire(input string tag, input int start);
    for (int k = 0; k < 5; k++) step(tag, 1'b1, (start + k) % 256, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_count = 8'h00;
    clear = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Acquire
    errs_a = 0; errs_b = 0; wraps_a = 0;
    acquire("acq", 8'h10);
    chk("acq locked",   {31'd0, locked_a}, 1);
    chk("acq expected", {24'd0, expected_a}, 32'h15);
    chk("acq errcnt",   {16'd0, err_count_a}, 0);
    chk("acq pulses",   errs_a + wraps_a, 0);

    // Wrap
    do_reset("wrap rst");
    acquire("wrap acq", 8'hF9);
    wraps_a = 0;
    for (int k = 0; k < 4; k++) step("wrap", 1'b1, (8'hFE + k) % 256, 1'b0);
    chk("wrap count",  wraps_a, 1);
    chk("wrap locked", {31'd0, locked_a}, 1);
    chk("wrap errcnt", {16'd0, err_count_a}, 0);

    // Single error
    do_reset("serr rst");
    acquire("serr acq", 8'h1B);
    chk("serr exp0", {24'd0, expected_a}, 32'h20);
    errs_a = 0;
    step("serr", 1'b1, 8'h25, 1'b0);
    step("serr", 1'b1, 8'h26, 1'b0);
    chk("serr pulses",   errs_a, 1);
    chk("serr errcnt",   {16'd0, err_count_a}, 1);
    chk("serr expected", {24'd0, expected_a}, 32'h27);
    chk("serr locked",   {31'd0, locked_a}, 1);

    // Unlock and reacquire
    step("unl clr", 1'b0, 0, 1'b1);
    for (int c = 8'h27; c <= 8'h2F; c++) step("unl pre", 1'b1, c, 1'b0);
    step("unl", 1'b1, 8'h40, 1'b0);
    step("unl", 1'b1, 8'h50, 1'b0);
    chk("unl errcnt", {16'd0, err_count_a}, 2);
    chk("unl locked", {31'd0, locked_a}, 0);
    errs_a = 0;
    for (int c = 8'h51; c <= 8'h54; c++) step("reacq", 1'b1, c, 1'b0);
    chk("reacq locked", {31'd0, locked_a}, 1);
    chk("reacq pulses", errs_a, 0);

    // Gaps and clear
    for (int c = 8'h55; c <= 8'h60; c++) step("gap pre", 1'b1, c, 1'b0);
    errs_a = 0;
    for (int k = 0; k < 5; k++) step("gap idle", 1'b0, 8'hAA, 1'b0);
    step("gap", 1'b1, 8'h61, 1'b0);
    chk("gap pulses", errs_a, 0);
    step("clr", 1'b1, 8'h99, 1'b1);
    chk("clr pulse",  {31'd0, err_pulse_a}, 1);
    chk("clr errcnt", {16'd0, err_count_a}, 0);

    // Saturation (instance b) and mid-stream reset
    do_reset("sat rst");
    acquire("sat acq", 8'h00);
    errs_b = 0;
    for (int k = 0; k < 5; k++) step("sat", 1'b1, 8'h80 + 16 * k, 1'b0);
    chk("sat errcnt", {30'd0, err_count_b}, 3);
    chk("sat pulses", errs_b, 5);
    chk("sat locked", {31'd0, locked_b}, 1);
    do_reset("mid rst");
    chk("mid locked_b", {31'd0, locked_b}, 0);
    step("post rst", 1'b1, 8'h42, 1'b0);
    chk("post rst exp", {24'd0, expected_a}, 32'h43);

    // Randomized stream
    for (int n = 0; n < 600; n++) begin
      int c;
      bit v, clr;
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd rst");
      end else begin
        v   = ($urandom_range(0, 9) < 8);
        clr = ($urandom_range(0, 19) == 0);
        c   = ($urandom_range(0, 9) < 7) ? m_exp[0] : int'($urandom_range(0, 255));
        step("rnd", v, c, clr);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
